uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Serial UART receiver for the ALU-over-UART design. It sits directly upstream of the interface circuit. It recovers 8N1 frames from the asynchronous `i_rx` line using an internally generated 16x oversampling tick. For each valid frame it presents the received word together with a one-cycle `o_rx_done` strobe, which the interface circuit consumes as its `i_data_rx` / `i_rx_done` pair.

## Interface
Parameters:
- `WIDTH_WORD`, 8: data bits per frame, sent LSB first.
- `TICKS_PER_BIT`, 16: oversampling ticks per bit. Must be even and ≥ 4.
- `BAUD_DIVISOR`, 163: clock cycles per oversampling tick (50 MHz / (19200·16)). Must be ≥ 1.

Ports:
- `i_clock`, in, 1: system clock; all logic on the rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_rx`, in, 1: serial line; idles high.
- `o_data_rx`, out, `WIDTH_WORD`: last correctly framed word.
- `o_rx_done`, out, 1: one-clock pulse when `o_data_rx` is updated.
- `o_frame_error`, out, 1: sticky flag; last frame had a low stop bit.
- `o_parity_error`, out, 1: last accepted frame failed the even-parity check. Constant 0 without `UART_RX_PARITY_EN`.

## Operation
**Reset** (`i_reset`=0, takes effect immediately):
- State = IDLE; synchronizer flops = 1.
- Tick divider, tick counter, bit index and shift register = 0.
- All outputs = 0.

**Input synchronizer:** two flops on `i_rx`. All decisions use the second flop, `rx_s`.

**Tick generator:**
- Free-running divider counts 0..`BAUD_DIVISOR`-1.
- `tick` is high for one clock when the divider equals `BAUD_DIVISOR`-1.
- The divider is never realigned to frames.

**State machine** (one-hot): IDLE, START, DATA, PARITY (present only with the macro), STOP. A 4-bit tick counter `s` advances only on `tick`.
- IDLE: when `rx_s`=0, go to START with `s`=0. The tick value is irrelevant.
- START: on `tick` with `s`=`TICKS_PER_BIT`/2-1:
  - if `rx_s`=0, go to DATA with `s`=0 and bit index `n`=0;
  - else it was a glitch: return to IDLE with no outputs changed.
  - Otherwise `s`++.
- DATA: on `tick` with `s`=`TICKS_PER_BIT`-1:
  - shift right, inserting `rx_s` at the MSB; `s`=0;
  - if `n`=`WIDTH_WORD`-1, go to PARITY (or STOP without the macro); else `n`++.
  - Otherwise `s`++.
- PARITY: on `tick` with `s`=`TICKS_PER_BIT`-1, latch `par_bad` = (^shift) ^ `rx_s`, then go to STOP with `s`=0.
- STOP: on `tick` with `s`=`TICKS_PER_BIT`-1:
  - `rx_s`=1 (good frame): `o_data_rx`←shift, `o_frame_error`←0, `o_parity_error`←`par_bad`, `o_rx_done`=1 for that single clock.
  - `rx_s`=0 (bad frame): `o_frame_error`←1; `o_data_rx`, `o_parity_error` and `o_rx_done` are unchanged (no strobe).
  - In both cases return to IDLE. A line still low remains in IDLE until it goes high then low again. This is implemented by an `armed` bit that is set when `rx_s`=1 is seen in IDLE.
- A parity-failed frame is still delivered with its strobe; the consumer decides what to do with it.

## Timing
- Samples are taken at mid-bit ±1 tick relative to the detected falling edge, plus 2 clocks of synchronizer delay.
- Latency from the falling edge of the start bit to the `o_rx_done` pulse is about (`TICKS_PER_BIT`/2 + (`WIDTH_WORD`+1[+1])·`TICKS_PER_BIT`)·`BAUD_DIVISOR` clocks, +2/+`BAUD_DIVISOR` clocks.
- `o_rx_done` is exactly one clock wide. `o_data_rx` is valid in the same cycle and holds until the next good frame.
- Back-to-back frames need no idle gap: IDLE is re-entered half a bit before the stop bit ends, and a start edge is accepted from then on.
- Reset asserted mid-frame discards the frame (no strobe). After release, reception resumes at the next high-then-low transition.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is start + `WIDTH_WORD` data + even-parity bit + stop. PARITY state is present and `o_parity_error` is active.
- Macro undefined: 8N1 framing only. PARITY state and `par_bad` are removed, and `o_parity_error` is tied to 0.

## Test plan
All tests use `BAUD_DIVISOR`=2 and `TICKS_PER_BIT`=16, so one bit lasts 32 clocks.
1. Reset, then send frame 0x35 → exactly one `o_rx_done` pulse; `o_data_rx`=0x35; `o_frame_error`=0.
2. Pull the line low for 8 clocks (4 ticks), then return high → no strobe; state back to IDLE; `o_data_rx` keeps its previous value.
3. Send 0x35 (good), then 0xC3 with stop bit = 0 → `o_frame_error`=1; no second strobe; `o_data_rx` stays 0x35. Then send 0x10 → strobe; `o_data_rx`=0x10; `o_frame_error`=0.
4. Send 0xA5 then 0x5A back-to-back with no idle gap → two strobes, carrying 0xA5 then 0x5A.
5. Assert reset during data bit 4 of frame 0xFF → outputs go to 0 with no strobe. Release reset and send 0x42 → `o_data_rx`=0x42.
6. With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → strobe, `o_parity_error`=1. Send 0x07 with parity bit 1 → `o_parity_error`=0.

Source files
------------

// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: receiver-side bundle of the UART serial line and the received-word outputs
//   master : line driver / word consumer (drives i_rx, reads results)
//   slave  : the receiver (reads i_rx, drives o_data_rx/o_rx_done/o_frame_error/o_parity_error)
interface uart_rx_oversampled_if #(
    parameter int WIDTH_WORD = 8
);
    logic                  i_rx;
    logic [WIDTH_WORD-1:0] o_data_rx;
    logic                  o_rx_done;
    logic                  o_frame_error;
    logic                  o_parity_error;
    modport master (output i_rx, input o_data_rx, o_rx_done, o_frame_error, o_parity_error);
    modport slave  (input i_rx, output o_data_rx, o_rx_done, o_frame_error, o_parity_error);
endinterface

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver (8N1, optional even parity via UART_RX_PARITY_EN)
//   i_clock        : system clock, rising edge
//   i_reset        : asynchronous active-low reset
//   bus.i_rx       : serial line, idles high
//   bus.o_data_rx  : last correctly framed word
//   bus.o_rx_done  : one-clock strobe when o_data_rx updates
//   bus.o_frame_error  : sticky, last frame had a low stop bit
//   bus.o_parity_error : last accepted frame failed even parity (0 without UART_RX_PARITY_EN)
module uart_rx_oversampled #(
    parameter int WIDTH_WORD    = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int BAUD_DIVISOR  = 163
) (
    input  logic i_clock,
    input  logic i_reset,
    uart_rx_oversampled_if.slave bus
);
    localparam int SW = $clog2(TICKS_PER_BIT);
    localparam int NW = $clog2(WIDTH_WORD + 1);
    localparam int DW = $clog2(BAUD_DIVISOR + 1);
    localparam logic [SW-1:0] S_HALF = SW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(TICKS_PER_BIT - 1);
    localparam logic [NW-1:0] N_LAST = NW'(WIDTH_WORD - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BAUD_DIVISOR - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [4:0] {
        IDLE = 5'b00001, START = 5'b00010, DATA = 5'b00100, PARITY = 5'b01000, STOP = 5'b10000
    } state_t;
    logic par_bad_q;
    logic perr_q;
`else
    typedef enum logic [3:0] {
        IDLE = 4'b0001, START = 4'b0010, DATA = 4'b0100, STOP = 4'b1000
    } state_t;
`endif

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [DW-1:0]         div_q, div_d;
    logic [SW-1:0]         s_q;
    logic [NW-1:0]         n_q;
    logic [WIDTH_WORD-1:0] shift_q, data_q;
    logic                  armed_q, done_q, ferr_q;
    logic                  tick, rx_s;

    assign rx_s  = sync_q[1];
    // Free-running divider: never realigned, so sample points jitter by up to one tick.
    assign tick  = div_q == D_LAST;
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            div_q     <= '0;
            s_q       <= '0;
            n_q       <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            armed_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], bus.i_rx};
            div_q  <= div_d;
            done_q <= 1'b0;
            case (state_q)
                // armed_q demands a high level before a start edge, so a stuck-low line is ignored.
                IDLE: begin
                    if (rx_s) armed_q <= 1'b1;
                    else if (armed_q) begin
                        armed_q <= 1'b0;
                        s_q     <= '0;
                        state_q <= START;
                    end
                end
                START: if (tick) begin
                    if (s_q == S_HALF) begin
                        s_q     <= '0;
                        n_q     <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else s_q <= s_q + 1'b1;
                end
                DATA: if (tick) begin
                    if (s_q == S_LAST) begin
                        shift_q <= {rx_s, shift_q[WIDTH_WORD-1:1]};
                        s_q     <= '0;
                        if (n_q == N_LAST)
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        else n_q <= n_q + 1'b1;
                    end else s_q <= s_q + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    if (s_q == S_LAST) begin
                        par_bad_q <= (^shift_q) ^ rx_s;
                        s_q       <= '0;
                        state_q   <= STOP;
                    end else s_q <= s_q + 1'b1;
                end
`endif
                // Decided mid stop bit, so the next start edge is accepted without an idle gap.
                STOP: if (tick) begin
                    if (s_q == S_LAST) begin
                        if (rx_s) begin
                            data_q <= shift_q;
                            done_q <= 1'b1;
                            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            perr_q <= par_bad_q;
`endif
                        end else ferr_q <= 1'b1;
                        s_q     <= '0;
                        state_q <= IDLE;
                    end else s_q <= s_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_data_rx     = data_q;
    assign bus.o_rx_done     = done_q;
    assign bus.o_frame_error = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_error = perr_q;
`else
    assign bus.o_parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed + random frames against a frame-level model of the receiver
module tb_uart_rx_oversampled;
    localparam int BD  = 2;
    localparam int TPB = 16;
    localparam int W   = 8;
    localparam int BIT = BD * TPB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_oversampled_if #(.WIDTH_WORD(W)) bus ();
    uart_rx_oversampled #(.WIDTH_WORD(W), .TICKS_PER_BIT(TPB), .BAUD_DIVISOR(BD)) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    int compared = 0;
    int mismatched = 0;
    int pulses = 0;
    int high_cycles = 0;
    logic prev_done = 1'b0;
    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_data = '0;
    logic exp_ferr = 1'b0;
    logic exp_perr = 1'b0;

    always @(negedge clk) begin
        if (bus.o_rx_done) begin
            high_cycles++;
            if (!prev_done) begin
                pulses++;
                rx_q.push_back(bus.o_data_rx);
            end
        end
        prev_done = bus.o_rx_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        bus.i_rx = v;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic idle(input int nbits);
        for (int i = 0; i < nbits; i++) bit_out(1'b1);
    endtask

    // Frame-level model: a high stop bit delivers the word; a low one only raises the frame error.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic flip);
        bit_out(1'b0);
        for (int i = 0; i < W; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^d) ^ flip);
`endif
        bit_out(stop);
        if (stop) begin
            exp_q.push_back(d);
            exp_data = d;
            exp_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
            exp_perr = flip;
`else
            exp_perr = 1'b0;
`endif
        end else exp_ferr = 1'b1;
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_word"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        rx_q.delete();
        exp_q.delete();
        check({tag, "_data"}, 32'(bus.o_data_rx), 32'(exp_data));
        check({tag, "_ferr"}, 32'(bus.o_frame_error), 32'(exp_ferr));
        check({tag, "_perr"}, 32'(bus.o_parity_error), 32'(exp_perr));
    endtask

    initial begin
        logic [W-1:0] d;
        logic stop;
        bus.i_rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(bus.o_data_rx), 32'h0);
        check("rst_done", 32'(bus.o_rx_done), 32'h0);
        check("rst_ferr", 32'(bus.o_frame_error), 32'h0);
        check("rst_perr", 32'(bus.o_parity_error), 32'h0);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'h35, 1'b1, 1'b0);
        idle(1);
        check_all("t1_good");
        bus.i_rx = 1'b0;
        repeat (8) @(posedge clk);
        idle(2);
        check_all("t2_glitch");
        send_frame(8'h35, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(2);
        check_all("t3_ferr");
        send_frame(8'h10, 1'b1, 1'b0);
        idle(1);
        check_all("t3_recover");
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(1);
        check_all("t4_b2b");
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        bus.i_rx = 1'b1;
        repeat (10) @(posedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        exp_data = '0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        check_all("t5_reset");
        @(posedge clk);
        rst_n = 1'b1;
        idle(5);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(1);
        check_all("t5_after");
        send_frame(8'h07, 1'b1, 1'b1);
        idle(1);
        check_all("t6_par_bad");
        send_frame(8'h07, 1'b1, 1'b0);
        idle(1);
        check_all("t6_par_ok");
        for (int k = 0; k < 24; k++) begin
            d = W'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send_frame(d, stop, 1'($urandom_range(0, 1)));
            idle(stop ? $urandom_range(0, 2) : $urandom_range(1, 2));
            check_all("rand");
        end
        check("done_width", 32'(high_cycles), 32'(pulses));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
